// File: rtl/rv32_regfile_sb.sv
// RV32 integer register file with a busy-bit scoreboard for in-flight writebacks.
// Two read ports and one write port; x0 is hardwired to zero.
module rv32_regfile_sb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned SYNC_READ = 0,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] din_i,
  output logic [XLEN-1:0] rs1d_o,
  output logic [XLEN-1:0] rs2d_o,
  input  logic            iss_i,
  input  logic [AW-1:0]   iss_rd_i,
  output logic            haz1_o,
  output logic            haz2_o,
  output logic [NREG-1:0] busy_o
);

  localparam bit BYP = (BYPASS != 0);
  localparam bit SRD = (SYNC_READ != 0);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt_c;
  logic [XLEN-1:0] rd1_c;
  logic [XLEN-1:0] rd2_c;
  logic            wr_en_c;

  assign wr_en_c = we_i && (rd_i != '0);

  // Storage; entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem[rd_i] <= din_i;
    end
  end

  // Read muxes with optional forwarding of the in-flight write.
  always_comb begin
    rd1_c = mem[rs1_i];
    if (BYP && wr_en_c && (rd_i == rs1_i)) rd1_c = din_i;
    if (rs1_i == '0) rd1_c = '0;
  end

  always_comb begin
    rd2_c = mem[rs2_i];
    if (BYP && wr_en_c && (rd_i == rs2_i)) rd2_c = din_i;
    if (rs2_i == '0) rd2_c = '0;
  end

  generate
    if (SRD) begin : g_sync_read
      logic [XLEN-1:0] rd1_q;
      logic [XLEN-1:0] rd2_q;

      always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_c;
          rd2_q <= rd2_c;
        end
      end

      assign rs1d_o = rd1_q;
      assign rs2d_o = rd2_q;
    end else begin : g_comb_read
      // Gate with reset so a forwarded din_i cannot leak out while in reset.
      assign rs1d_o = rst_in ? rd1_c : '0;
      assign rs2d_o = rst_in ? rd2_c : '0;
    end
  endgenerate

  // Scoreboard next state: writeback clears, issue sets, set wins on collision.
  always_comb begin
    busy_nxt_c = busy;
    if (we_i) busy_nxt_c[rd_i] = 1'b0;
    if (iss_i && (iss_rd_i != '0)) busy_nxt_c[iss_rd_i] = 1'b1;
    busy_nxt_c[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt_c;
    end
  end

  assign busy_o = busy;
  assign haz1_o = busy[rs1_i] & ~(BYP & we_i & (rd_i == rs1_i)) & (rs1_i != '0);
  assign haz2_o = busy[rs2_i] & ~(BYP & we_i & (rd_i == rs2_i)) & (rs2_i != '0);

endmodule

// File: doc/rv32_regfile_sb.md
RV32_REGFILE_SB -- requirements
Module: rv32_regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, register count; legal values 16 (RV32E) or 32 (RV32I); localparam AW = clog2(NREG).
REQ-003 Parameter BYPASS, default 1, forwards same-cycle write data to the read ports when 1.
REQ-004 Parameter SYNC_READ, default 0; 0 = combinational read, 1 = registered read with 1-cycle latency.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-low.
REQ-007 rs1_i  input  AW  read port 1 address.
REQ-008 rs2_i  input  AW  read port 2 address.
REQ-009 rd_i  input  AW  write address.
REQ-010 we_i  input  1  write enable.
REQ-011 din_i  input  XLEN  write data.
REQ-012 rs1d_o  output  XLEN  read port 1 data.
REQ-013 rs2d_o  output  XLEN  read port 2 data.
REQ-014 iss_i  input  1  issue strobe; marks iss_rd_i busy (pending writeback).
REQ-015 iss_rd_i  input  AW  destination of the issued instruction.
REQ-016 haz1_o  output  1  rs1_i names a busy register.
REQ-017 haz2_o  output  1  rs2_i names a busy register.
REQ-018 busy_o  output  NREG  scoreboard vector; bit n = register n pending.

Function
REQ-019 Register 0 SHALL read as zero at all times; writes to 0 are discarded and iss_i with iss_rd_i=0 sets no busy bit.
REQ-020 A write occurs on the rising edge when we_i=1 and rd_i!=0: mem[rd_i] <= din_i; no other register changes.
REQ-021 SYNC_READ=0: rsNd_o SHALL be combinational from rsN_i and current storage.
REQ-022 SYNC_READ=1: rsN_i SHALL be sampled at each rising edge; rsNd_o presents that register's data from the following edge and holds until the next edge.
REQ-023 BYPASS=1: when we_i=1, rd_i!=0 and rd_i equals the (SYNC_READ=1: sampled) read address, that port SHALL return din_i in the same cycle instead of the old value.
REQ-024 BYPASS=0: a read of the register being written SHALL return the pre-write value for SYNC_READ=0 and for SYNC_READ=1.
REQ-025 Scoreboard: on the rising edge, iss_i=1 sets busy[iss_rd_i]; we_i=1 clears busy[rd_i].
REQ-026 Same-edge set and clear of the same register: set wins (busy stays 1).
REQ-027 Writes to a non-busy register SHALL be accepted and leave busy at 0.
REQ-028 haz1_o = busy[rs1_i] & ~(we_i & rd_i==rs1_i & BYPASS) & (rs1_i!=0), combinational; haz2_o likewise for rs2_i.
REQ-029 With BYPASS=0 a hazard SHALL persist until the cycle after the clearing write.
REQ-030 Out-of-range addresses (NREG=16, bit 4 absent) are impossible by width; the port is AW bits wide only.

Reset
REQ-031 rst_in low SHALL asynchronously clear all registers, all busy bits, and SYNC_READ output registers to 0.
REQ-032 During reset rsNd_o=0, haz1_o=haz2_o=0, busy_o=0; writes and issues are ignored.
REQ-033 Reset release mid-operation SHALL discard pending scoreboard entries; the first edge after release behaves normally.

Verification
REQ-034 Reset, write x5=0xDEADBEEF, read rs1=5 -> rs1d_o=0xDEADBEEF (SYNC_READ=1: one cycle later).
REQ-035 we_i=1 rd=0 din=0xFFFFFFFF, then rs1=0 -> rs1d_o=0; iss_i with iss_rd_i=0 -> busy_o=0.
REQ-036 BYPASS=1, x7=0x11, same cycle we_i=1 rd=7 din=0x22 with rs2=7 -> rs2d_o=0x22; BYPASS=0 -> 0x11, then 0x22 next cycle.
REQ-037 iss x3, rs1=3 -> haz1_o=1 until write to x3; same-cycle write with BYPASS=1 -> haz1_o=0 and busy[3]=0 next cycle.
REQ-038 Same edge iss_i rd=4 and we_i rd=4 -> busy[4]=1 after edge; mem[4]=din_i.
REQ-039 Registers/busy loaded, assert rst_in mid-cycle -> all outputs 0 immediately without a clock edge; NREG=16 build repeats REQ-034 on x15.
